// File: rtl/parity_acc.sv
// Parity-protected 4-bit accumulator controller wrapped around an external
// parity-checked adder: accepts parity-tagged operands, drives the adder and keeps sticky error flags.
module parity_acc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_data,
  input  logic         in_par,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_err,
  output logic [W-1:0] acc,
  output logic         acc_par,
  output logic         carry,
  output logic         err_in,
  output logic         err_add,
  input  logic         clr_err,
  output logic [W-1:0] add_x,
  output logic [W-1:0] add_y,
  output logic         add_ci,
  output logic         add_xp,
  output logic         add_yp,
  input  logic [W-1:0] add_z,
  input  logic         add_zp,
  input  logic         add_co,
  input  logic         add_err
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_ADC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t         state;
  logic [W-1:0]   y_q;
  logic           yp_q;
  logic           ci_q;
  logic           err_q;

  logic accept;
  logic chk;
  logic set_in;
  logic set_add;

  assign accept  = (state == IDLE) && in_valid;
  assign chk     = (^in_data) ^ in_par;
  assign set_in  = accept && chk && (in_op != OP_CLEAR);
  assign set_add = (state == ADD) && add_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      acc_par <= 1'b0;
      carry   <= 1'b0;
      y_q     <= '0;
      yp_q    <= 1'b0;
      ci_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in this block samples the pre-edge values of its neighbours.
      case (state)
        IDLE: begin
          if (accept) begin
            y_q  <= in_data;
            yp_q <= in_par;
            // Carry-in is frozen at accept; carry cannot change before ADD.
            ci_q <= (in_op == OP_ADC) ? carry : 1'b0;
            if (in_op == OP_CLEAR) begin
              acc     <= '0;
              acc_par <= 1'b0;
              carry   <= 1'b0;
              err_q   <= 1'b0;
              state   <= DONE;
            end else if (chk) begin
              err_q <= 1'b1;
              state <= DONE;
            end else if (in_op == OP_LOAD) begin
              acc     <= in_data;
              acc_par <= in_par;
              err_q   <= 1'b0;
              state   <= DONE;
            end else begin
              state <= ADD;
            end
          end
        end
        ADD: begin
          if (add_err) begin
            err_q <= 1'b1;
          end else begin
            acc     <= add_z;
            acc_par <= add_zp;
            carry   <= add_co;
            err_q   <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A set event in the same cycle takes priority over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_in  <= 1'b0;
      err_add <= 1'b0;
    end else begin
      if (set_in)       err_in <= 1'b1;
      else if (clr_err) err_in <= 1'b0;
      if (set_add)      err_add <= 1'b1;
      else if (clr_err) err_add <= 1'b0;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_err   = out_valid & err_q;

  assign add_x  = acc;
  assign add_xp = acc_par;
  assign add_y  = y_q;
  assign add_yp = yp_q;
  assign add_ci = ci_q;

endmodule
